// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch and PC sequencing stage
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [5:0]  Opcode,
  output logic [5:0]  FuncCode,
  output logic        InstrValid,
  input  logic        Retire,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        ALUZero,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] InstrCount,
  output logic        FetchFault
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Last counter value before a stalled fetch is declared faulty.
  localparam logic [31:0] TMO_LAST = 32'(FETCH_TIMEOUT) - 32'd1;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic        fetch_fault;
  logic [31:0] tmo_cnt;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        fetch_accept;
  logic        timeout_hit;
  logic        retire_fire;

  assign pc_plus4 = pc + 32'd4;

  // Handshake qualifiers: ready and retire only matter in their own state.
  assign fetch_accept = (state == S_FETCH) && IMemReady;
  assign timeout_hit  = (state == S_FETCH) && !IMemReady &&
                        (FETCH_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign retire_fire  = (state == S_EXEC) && Retire;

  // Next PC: jump beats taken branch beats sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    end else if (Branch && ALUZero) begin
      next_pc = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; HALT is only left through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: begin
        if (fetch_accept) begin
          state_next = S_EXEC;
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_EXEC:  if (retire_fire) state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_BOOT;
    endcase
  end

  // Datapath: IR load on accept, PC/count update on retire, stall timer.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      ir          <= 32'd0;
      instr_valid <= 1'b0;
      instr_count <= 32'd0;
      fetch_fault <= 1'b0;
      tmo_cnt     <= 32'd0;
    end else begin
      if (fetch_accept) begin
        ir          <= IMemData;
        instr_valid <= 1'b1;
      end else if (timeout_hit) begin
        fetch_fault <= 1'b1;
      end else if (state == S_FETCH) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (retire_fire) begin
        pc          <= next_pc;
        instr_count <= instr_count + 32'd1;
        instr_valid <= 1'b0;
        tmo_cnt     <= 32'd0;
      end
    end
  end

  assign IMemReq     = (state == S_FETCH);
  assign IMemAddr    = pc;
  assign Instruction = ir;
  assign Opcode      = ir[31:26];
  assign FuncCode    = ir[5:0];
  assign InstrValid  = instr_valid;
  assign PC          = pc;
  assign PCPlus4     = pc_plus4;
  assign InstrCount  = instr_count;
  assign FetchFault  = fetch_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData = 32'd0;
  logic [31:0] Instruction;
  logic [5:0]  Opcode;
  logic [5:0]  FuncCode;
  logic        InstrValid;
  logic        Retire = 1'b0;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        ALUZero = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] InstrCount;
  logic        FetchFault;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_cnt;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .CLK(CLK), .Reset(Reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .Instruction(Instruction), .Opcode(Opcode), .FuncCode(FuncCode), .InstrValid(InstrValid),
    .Retire(Retire), .Branch(Branch), .Jump(Jump), .ALUZero(ALUZero),
    .PC(PC), .PCPlus4(PCPlus4), .InstrCount(InstrCount), .FetchFault(FetchFault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                           input logic b, input logic j, input logic z);
    logic [31:0] seq;
    logic signed [31:0] off;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = 32'(signed'(ir[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic do_fetch(input int stall, input logic [31:0] word);
    int n = 0;
    while (!IMemReq && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check("req_seen", 32'(IMemReq), 32'd1);
    check("imem_addr", IMemAddr, m_pc);
    for (int i = 0; i < stall; i++) begin
      IMemReady = 1'b0;
      @(negedge CLK);
      check("stall_req", 32'(IMemReq), 32'd1);
      check("stall_addr", IMemAddr, m_pc);
      check("stall_valid", 32'(InstrValid), 32'd0);
      check("stall_fault", 32'(FetchFault), 32'd0);
    end
    IMemReady = 1'b1;
    IMemData  = word;
    @(negedge CLK);
    IMemReady = 1'b0;
    IMemData  = $urandom;
    m_ir = word;
    check("ir", Instruction, m_ir);
    check("opcode", 32'(Opcode), m_ir >> 26);
    check("funccode", 32'(FuncCode), m_ir & 32'h3F);
    check("valid_exec", 32'(InstrValid), 32'd1);
    check("req_exec", 32'(IMemReq), 32'd0);
    check("pc_exec", PC, m_pc);
    check("pcplus4", PCPlus4, m_pc + 32'd4);
  endtask

  task automatic do_retire(input int hold, input logic b, input logic j, input logic z);
    for (int i = 0; i < hold; i++) begin
      Retire    = 1'b0;
      Branch    = 1'($urandom);
      Jump      = 1'($urandom);
      ALUZero   = 1'($urandom);
      IMemReady = 1'($urandom);
      IMemData  = $urandom;
      @(negedge CLK);
      check("hold_valid", 32'(InstrValid), 32'd1);
      check("hold_req", 32'(IMemReq), 32'd0);
      check("hold_pc", PC, m_pc);
      check("hold_ir", Instruction, m_ir);
    end
    IMemReady = 1'b0;
    Retire    = 1'b1;
    Branch    = b;
    Jump      = j;
    ALUZero   = z;
    @(negedge CLK);
    Retire = 1'b0;
    Branch = 1'($urandom);
    Jump   = 1'($urandom);
    m_pc  = ref_next(m_pc, m_ir, b, j, z);
    m_cnt = m_cnt + 32'd1;
    check("retire_pc", PC, m_pc);
    check("retire_cnt", InstrCount, m_cnt);
    check("retire_valid", 32'(InstrValid), 32'd0);
    check("retire_req", 32'(IMemReq), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, PC, 32'd0);
    check({tag, "_ir"}, Instruction, 32'd0);
    check({tag, "_opcode"}, 32'(Opcode), 32'd0);
    check({tag, "_valid"}, 32'(InstrValid), 32'd0);
    check({tag, "_req"}, 32'(IMemReq), 32'd0);
    check({tag, "_cnt"}, InstrCount, 32'd0);
    check({tag, "_fault"}, 32'(FetchFault), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    Reset = 1'b0;
    m_pc  = 32'd0;
    m_cnt = 32'd0;
    m_ir  = 32'd0;
    #1;
    check("boot_req", 32'(IMemReq), 32'd0);
    @(negedge CLK);
    check("boot_to_fetch_req", 32'(IMemReq), 32'd1);
  endtask

  initial begin
    logic [31:0] cnt_hold;
    logic [31:0] pc_hold;
    m_pc = 32'd0; m_cnt = 32'd0; m_ir = 32'd0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    release_reset();

    // Sequential fetch: 0, 4, 8, C.
    for (int i = 0; i < 4; i++) begin
      do_fetch(0, $urandom);
      do_retire(0, 1'b0, 1'b0, 1'($urandom));
    end
    check("seq_count", InstrCount, 32'd4);

    // Five-cycle memory stall.
    do_fetch(5, $urandom);
    do_retire(1, 1'b0, 1'b0, 1'b0);

    // Jump to 0x100, then BEQ taken with imm -2.
    do_fetch(0, 32'h0800_0040);
    do_retire(0, 1'($urandom), 1'b1, 1'($urandom));
    check("jump_0x100", PC, 32'h0000_0100);
    do_fetch(0, 32'h1021_FFFE);
    do_retire(0, 1'b1, 1'b0, 1'b1);
    check("beq_taken", PC, 32'h0000_00FC);

    // Asynchronous reset mid-EXEC with seven retired instructions.
    do_fetch(0, $urandom);
    check("cnt_before_rst", InstrCount, 32'd7);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    release_reset();

    // Wrap and upper-nibble cases.
    do_fetch(0, 32'h1021_FFFE);
    do_retire(0, 1'b1, 1'b0, 1'b1);
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    do_fetch(0, 32'h0800_0040);
    do_retire(0, 1'b1, 1'b1, 1'b0);
    check("jump_wrap", PC, 32'h0000_0100);
    do_fetch(0, 32'h1021_FFFE);
    do_retire(0, 1'b1, 1'b0, 1'b0);
    check("beq_not_taken", PC, 32'h0000_0104);
    do_fetch(0, 32'h0800_0000);
    do_retire(0, 1'b0, 1'b1, 1'b0);
    do_fetch(0, 32'h1021_FFFD);
    do_retire(0, 1'b1, 1'b0, 1'b1);
    check("beq_neg8", PC, 32'hFFFF_FFF8);
    do_fetch(0, 32'h0800_0040);
    do_retire(0, 1'b0, 1'b1, 1'b1);
    check("jump_high", PC, 32'hF000_0100);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      do_fetch($urandom_range(0, 6), $urandom);
      do_retire($urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom));
    end

    // Fetch timeout: 16 FETCH cycles with no ready.
    IMemReady = 1'b0;
    repeat (15) @(negedge CLK);
    check("tmo_req_last", 32'(IMemReq), 32'd1);
    check("tmo_fault_early", 32'(FetchFault), 32'd0);
    @(negedge CLK);
    check("tmo_fault", 32'(FetchFault), 32'd1);
    check("tmo_req_off", 32'(IMemReq), 32'd0);
    cnt_hold = InstrCount;
    pc_hold  = PC;
    check("tmo_cnt_model", cnt_hold, m_cnt);
    for (int i = 0; i < 6; i++) begin
      IMemReady = 1'($urandom);
      Retire    = 1'($urandom);
      IMemData  = $urandom;
      @(negedge CLK);
    end
    IMemReady = 1'b0;
    Retire    = 1'b0;
    check("halt_fault", 32'(FetchFault), 32'd1);
    check("halt_req", 32'(IMemReq), 32'd0);
    check("halt_valid", 32'(InstrValid), 32'd0);
    check("halt_cnt", InstrCount, m_cnt);
    check("halt_pc", PC, m_pc);

    // Reset clears the sticky fault and restarts at address 0.
    Reset = 1'b1;
    #1;
    check_reset_outputs("final_rst");
    release_reset();
    do_fetch(0, $urandom);
    do_retire(0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and PC-sequencing stage that sits directly upstream of the single-cycle control decoder.
- Holds the PC and requests instructions from instruction memory over a req/ready handshake.
- Latches each fetched word and presents Opcode/FuncCode to the decoder.
- Consumes the decoder's Branch/Jump outputs plus the ALU Zero flag to compute the next PC when the instruction retires.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FETCH_TIMEOUT, 16, max cycles in FETCH without IMemReady before fault; 0 disables timeout.

Ports:
CLK  input  1  clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset.
IMemReq  output  1  fetch request, held high until accepted.
IMemAddr  output  32  fetch address, equals PC while IMemReq=1.
IMemReady  input  1  memory accepts request; IMemData valid same cycle.
IMemData  input  32  instruction word.
Instruction  output  32  latched instruction register (IR).
Opcode  output  6  IR[31:26].
FuncCode  output  6  IR[5:0].
InstrValid  output  1  IR holds an instruction awaiting retire.
Retire  input  1  execute/writeback complete for current IR.
Branch  input  1  from control decoder.
Jump  input  1  from control decoder.
ALUZero  input  1  ALU result zero (BEQ equality).
PC  output  32  address of current IR.
PCPlus4  output  32  PC + 4, combinational.
InstrCount  output  32  retired-instruction counter.
FetchFault  output  1  sticky timeout flag.

Behaviour:
- Reset (async, any state, including mid-fetch): PC=RESET_PC, IR=0, InstrValid=0, IMemReq=0, InstrCount=0, FetchFault=0, state=BOOT, timeout counter=0.
- States:
  - BOOT: one cycle after Reset deasserts, then go to FETCH. Outputs idle.
  - FETCH: IMemReq=1, IMemAddr=PC.
    - IMemReady=1: IR<=IMemData, InstrValid<=1, go to EXEC. Minimum fetch latency is 1 cycle from entering FETCH to IR valid.
    - IMemReady=0: timeout counter increments.
    - Counter reaches FETCH_TIMEOUT-1 with no ready (FETCH_TIMEOUT≠0): FetchFault<=1, go to HALT.
  - EXEC: IMemReq=0, InstrValid=1, Opcode/FuncCode driven from IR. Wait indefinitely for Retire.
    - On Retire: PC<=NextPC, InstrCount<=InstrCount+1, InstrValid<=0, timeout counter<=0, go to FETCH.
  - HALT: IMemReq=0, InstrValid=0. Only Reset exits.
- IMemReady is ignored outside FETCH. Retire is ignored outside EXEC.
- IMemAddr holds its value while IMemReq=1; it does not change until acceptance.
- NextPC is evaluated combinationally in EXEC, priority order:
  1. Jump=1 → {PCPlus4[31:28], IR[25:0], 2'b00}. Branch is don't-care.
  2. Branch=1 and ALUZero=1 → PCPlus4 + ({{14{IR[15]}}, IR[15:0], 2'b00}).
  3. Otherwise → PCPlus4.
- Arithmetic is 32-bit modulo 2^32; PC wraps 32'hFFFF_FFFC → 0 silently. InstrCount also wraps silently.
- Branch and Jump are sampled only on the Retire cycle. X values on Branch/Jump outside that cycle must not propagate into state.
- Retire and Reset together: Reset wins.
- The PC low two bits are always 00 by construction.

Test Plan:
- Reset with RESET_PC=0: release, ready every cycle, Retire each EXEC, no Branch/Jump → IMemAddr sequence 0,4,8,C; InstrCount=4 after four retires.
- Memory stall: hold IMemReady=0 for 5 cycles (FETCH_TIMEOUT=16) → IMemReq stays 1, IMemAddr stable; IR loads on the 6th cycle; FetchFault=0.
- BEQ taken: PC=0x100, IR imm16=0xFFFE, Branch=1, ALUZero=1, Retire → next IMemAddr=0x0FC. Same with ALUZero=0 → 0x104.
- Jump: PC=0x3000_0010, IR[25:0]=0x0000040, Jump=1, Branch=x, Retire → next IMemAddr=0x3000_0100.
- Timeout: IMemReady held 0, FETCH_TIMEOUT=16 → FetchFault=1 after 16 FETCH cycles, IMemReq=0; later IMemReady/Retire pulses have no effect until Reset.
- Async reset mid-EXEC with InstrCount=7 → all outputs return to reset values immediately, without waiting for a CLK edge; fetch restarts at RESET_PC.
